// File: rtl/rtc_ajuste_pkg.sv
// Shared definitions for the RTC field-edit stage: field codes, FSM states,
// per-field BCD limits and small BCD helpers.
package rtc_ajuste_pkg;

  localparam logic [3:0] SEL_SEG    = 4'd0;
  localparam logic [3:0] SEL_MIN    = 4'd1;
  localparam logic [3:0] SEL_HORA   = 4'd2;
  localparam logic [3:0] SEL_DAY    = 4'd3;
  localparam logic [3:0] SEL_MONTH  = 4'd4;
  localparam logic [3:0] SEL_YEAR   = 4'd5;
  localparam logic [3:0] SEL_SEG_T  = 4'd6;
  localparam logic [3:0] SEL_MIN_T  = 4'd7;
  localparam logic [3:0] SEL_HORA_T = 4'd8;

  typedef enum logic [1:0] {IDLE, CAPTURE, EDIT, WRITE} state_t;

  localparam logic [7:0] MIN_ZERO      = 8'h00;
  localparam logic [7:0] MAX_SEG       = 8'h59;
  localparam logic [7:0] MIN_DAY       = 8'h01;
  localparam logic [7:0] MAX_DAY       = 8'h31;
  localparam logic [7:0] MAX_DAY_SHORT = 8'h30;
  localparam logic [7:0] MAX_DAY_FEB   = 8'h28;
  localparam logic [7:0] MAX_DAY_LEAP  = 8'h29;
  localparam logic [7:0] MIN_MONTH     = 8'h01;
  localparam logic [7:0] MAX_MONTH     = 8'h12;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Divisible by 4 iff (2*tens + ones) mod 4 == 0; only tens[0] and ones[1:0] matter.
  function automatic logic bcd_leap(input logic [7:0] y);
    logic [1:0] s;
    s = y[1:0] + {y[4], 1'b0};
    return s == 2'b00;
  endfunction

endpackage

// File: rtl/bcd_step.sv
// Combinational two-digit packed-BCD +1/-1 with wrap between min_v and max_v.
module bcd_step (
  input  logic [7:0] val,
  input  logic [7:0] min_v,
  input  logic [7:0] max_v,
  input  logic       up,
  input  logic       down,
  output logic [7:0] nxt
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    nxt = val;
    if (up && !down) begin
      // >= so a value left above a shrunken maximum still wraps on the next up-step
      if (val >= max_v)            nxt = min_v;
      else if (val[3:0] == 4'd9)   nxt = {val[7:4] + 4'd1, 4'd0};
      else                         nxt = {val[7:4], val[3:0] + 4'd1};
    end else if (down && !up) begin
      if (val <= min_v)            nxt = max_v;
      else if (val[3:0] == 4'd0)   nxt = {val[7:4] - 4'd1, 4'd9};
      else                         nxt = {val[7:4], val[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/ajuste_bcd_campo.sv
// Field edit stage: capture a BCD field, step it with per-field wrap, emit a write pulse.
// Optional macro DAY_LIMIT_MONTH_EN: day maximum follows month_bcd/year_bcd.
module ajuste_bcd_campo
  import rtc_ajuste_pkg::*;
#(
  parameter logic [7:0] HORA_MAX = 8'h23,
  parameter logic [7:0] YEAR_MAX = 8'h99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Ld_BCD,
  input  logic [3:0] sel_LD,
  input  logic [7:0] month_bcd,
  input  logic [7:0] year_bcd,
  input  logic       edit_start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       edit_commit,
  input  logic       edit_cancel,
  output logic [7:0] bcd_out,
  output logic       busy,
  output logic       wr_pulse,
  output logic [7:0] wr_data,
  output logic [3:0] wr_sel
);

  state_t     state;
  logic [3:0] sel_q;
  logic [7:0] val;
  logic [7:0] day_max;
  logic [7:0] fmin, fmax;
  logic [7:0] ld_fix, cap_val, step_val;
  logic       step_up, step_down;

`ifdef DAY_LIMIT_MONTH_EN
  always_comb begin
    case (month_bcd)
      8'h02:                      day_max = bcd_leap(year_bcd) ? MAX_DAY_LEAP : MAX_DAY_FEB;
      8'h04, 8'h06, 8'h09, 8'h11: day_max = MAX_DAY_SHORT;
      default:                    day_max = MAX_DAY;
    endcase
  end
`else
  logic unused_calendar;
  assign unused_calendar = ^{month_bcd, year_bcd};
  assign day_max = MAX_DAY;
`endif

  // Limits follow the latched field code; unknown codes fall back to the seconds range.
  always_comb begin
    fmin = MIN_ZERO;
    fmax = MAX_SEG;
    case (sel_q)
      SEL_HORA, SEL_HORA_T: fmax = HORA_MAX;
      SEL_DAY:   begin fmin = MIN_DAY;   fmax = day_max;   end
      SEL_MONTH: begin fmin = MIN_MONTH; fmax = MAX_MONTH; end
      SEL_YEAR:  fmax = YEAR_MAX;
      default: ;
    endcase
  end

  always_comb begin
    ld_fix = Ld_BCD;
    if (sel_q == SEL_HORA) ld_fix[7] = 1'b0;
    cap_val = (!bcd_valid(ld_fix) || ld_fix < fmin || ld_fix > fmax) ? fmin : ld_fix;
  end

  // Buttons only act in EDIT and never in a commit or cancel cycle.
  assign step_up   = btn_up   && (state == EDIT) && !edit_commit && !edit_cancel;
  assign step_down = btn_down && (state == EDIT) && !edit_commit && !edit_cancel;

  bcd_step u_step (
    .val   (val),
    .min_v (fmin),
    .max_v (fmax),
    .up    (step_up),
    .down  (step_down),
    .nxt   (step_val)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sel_q    <= 4'h0;
      val      <= 8'h00;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      wr_data  <= 8'h00;
      wr_sel   <= 4'h0;
    end else begin
      wr_pulse <= 1'b0;
      case (state)
        IDLE: if (edit_start) begin
          state <= CAPTURE;
          sel_q <= sel_LD;
          busy  <= 1'b1;
        end
        CAPTURE: begin
          val   <= cap_val;
          state <= EDIT;
        end
        EDIT: begin
          if (edit_cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (edit_commit) begin
            state    <= WRITE;
            wr_pulse <= 1'b1;
            wr_data  <= val;
            wr_sel   <= sel_q;
          end else begin
            val <= step_val;
          end
        end
        WRITE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd_out = val;

endmodule

// File: tb/tb_ajuste_bcd_campo.sv
// Self-checking bench for ajuste_bcd_campo; expected writes go through a scoreboard queue.
module tb_ajuste_bcd_campo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Ld_BCD;
  logic [3:0] sel_LD;
  logic [7:0] month_bcd, year_bcd;
  logic       edit_start, btn_up, btn_down, edit_commit, edit_cancel;
  logic [7:0] bcd_out;
  logic       busy, wr_pulse;
  logic [7:0] wr_data;
  logic [3:0] wr_sel;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] sel;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  passed = 0;
  int  total  = 0;
  int  wr_seen = 0;
  int  seen0;

  ajuste_bcd_campo dut (
    .clk         (clk),
    .reset       (reset),
    .Ld_BCD      (Ld_BCD),
    .sel_LD      (sel_LD),
    .month_bcd   (month_bcd),
    .year_bcd    (year_bcd),
    .edit_start  (edit_start),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .edit_commit (edit_commit),
    .edit_cancel (edit_cancel),
    .bcd_out     (bcd_out),
    .busy        (busy),
    .wr_pulse    (wr_pulse),
    .wr_data     (wr_data),
    .wr_sel      (wr_sel)
  );

  always #5 clk = ~clk;

  // Write monitor: every pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (reset === 1'b1 && wr_pulse === 1'b1) begin
      wr_seen++;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write actual data=%h sel=%h required no write", wr_data, wr_sel);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wr_data, wr_sel} !== mon_e)
          $display("FAIL write_data actual data=%h sel=%h required data=%h sel=%h",
                   wr_data, wr_sel, mon_e.data, mon_e.sel);
        else passed++;
      end
    end
  end

  // Called just after a negedge; applies one cycle of inputs and returns at the next negedge.
  task automatic drive(input logic st, input logic up, input logic dn, input logic cm, input logic cn);
    edit_start = st; btn_up = up; btn_down = dn; edit_commit = cm; edit_cancel = cn;
    @(posedge clk);
    #1;
    edit_start = 1'b0; btn_up = 1'b0; btn_down = 1'b0; edit_commit = 1'b0; edit_cancel = 1'b0;
    @(negedge clk);
  endtask

  task automatic start(input logic [3:0] s, input logic [7:0] v);
    sel_LD = s;
    Ld_BCD = v;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    total++;
    if ({bcd_out, busy, wr_pulse, wr_data, wr_sel} !== 22'h0)
      $display("FAIL reset_state actual out=%h busy=%b pulse=%b data=%h sel=%h required all zero",
               bcd_out, busy, wr_pulse, wr_data, wr_sel);
    else passed++;
  endtask

  task automatic test_seg_wrap;
    seen0 = wr_seen;
    start(4'd0, 8'h59);
    total++; if (bcd_out !== 8'h59) $display("FAIL seg_capture actual=%h required=59", bcd_out); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL seg_busy actual=%b required=1", busy); else passed++;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h00) $display("FAIL seg_wrap_up actual=%h required=00", bcd_out); else passed++;
    exp_q.push_back('{data: 8'h00, sel: 4'd0});
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (busy !== 1'b0) $display("FAIL seg_busy_after actual=%b required=0", busy); else passed++;
    total++; if (wr_seen !== seen0 + 1) $display("FAIL seg_write_count actual=%0d required=%0d", wr_seen - seen0, 1); else passed++;
    total++; if (bcd_out !== 8'h00) $display("FAIL seg_hold_idle actual=%h required=00", bcd_out); else passed++;
  endtask

  task automatic test_month;
    seen0 = wr_seen;
    start(4'd4, 8'h01);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h12) $display("FAIL month_wrap_down actual=%h required=12", bcd_out); else passed++;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h01) $display("FAIL month_wrap_up actual=%h required=01", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (busy !== 1'b0) $display("FAIL month_cancel_busy actual=%b required=0", busy); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (wr_seen !== seen0) $display("FAIL month_cancel_write actual=%0d required=0", wr_seen - seen0); else passed++;
  endtask

  task automatic test_hour;
    start(4'd2, 8'h3A);
    total++; if (bcd_out !== 8'h00) $display("FAIL hour_invalid actual=%h required=00", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h23) $display("FAIL hour_wrap_down actual=%h required=23", bcd_out); else passed++;
    exp_q.push_back('{data: 8'h23, sel: 4'd2});
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start(4'd2, 8'h92);
    total++; if (bcd_out !== 8'h12) $display("FAIL hour_bit7_masked actual=%h required=12", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    start(4'd8, 8'h24);
    total++; if (bcd_out !== 8'h00) $display("FAIL hora_t_range actual=%h required=00", bcd_out); else passed++;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h01) $display("FAIL hora_t_up actual=%h required=01", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_year;
    seen0 = wr_seen;
    start(4'd5, 8'h09);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h09) $display("FAIL year_both_buttons actual=%h required=09", bcd_out); else passed++;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h10) $display("FAIL year_carry actual=%h required=10", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total++; if (busy !== 1'b0) $display("FAIL year_cancel_wins actual busy=%b required=0", busy); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (wr_seen !== seen0) $display("FAIL year_no_write actual=%0d required=0", wr_seen - seen0); else passed++;
    start(4'd5, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h99) $display("FAIL year_wrap_down actual=%h required=99", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h98) $display("FAIL year_down actual=%h required=98", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_day;
    start(4'd3, 8'h31);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h01) $display("FAIL day_wrap_up actual=%h required=01", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h31) $display("FAIL day_wrap_down actual=%h required=31", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    start(4'd3, 8'h00);
    total++; if (bcd_out !== 8'h01) $display("FAIL day_below_min actual=%h required=01", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_raw_code;
    start(4'd12, 8'h45);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h46) $display("FAIL raw_up actual=%h required=46", bcd_out); else passed++;
    sel_LD = 4'd1;
    Ld_BCD = 8'h07;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h46) $display("FAIL start_in_edit actual=%h required=46", bcd_out); else passed++;
    exp_q.push_back('{data: 8'h46, sel: 4'd12});
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start(4'd15, 8'h60);
    total++; if (bcd_out !== 8'h00) $display("FAIL raw_range actual=%h required=00", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_edit;
    seen0 = wr_seen;
    start(4'd1, 8'h30);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h31) $display("FAIL min_up actual=%h required=31", bcd_out); else passed++;
    #2 reset = 1'b0;
    #1;
    total++;
    if ({bcd_out, busy, wr_pulse, wr_data, wr_sel} !== 22'h0)
      $display("FAIL reset_mid_edit actual out=%h busy=%b pulse=%b data=%h sel=%h required all zero",
               bcd_out, busy, wr_pulse, wr_data, wr_sel);
    else passed++;
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (wr_seen !== seen0) $display("FAIL reset_no_write actual=%0d required=0", wr_seen - seen0); else passed++;
    total++; if (busy !== 1'b0 || bcd_out !== 8'h00)
      $display("FAIL reset_idle actual busy=%b out=%h required busy=0 out=00", busy, bcd_out);
    else passed++;
  endtask

`ifdef DAY_LIMIT_MONTH_EN
  task automatic test_day_limit;
    month_bcd = 8'h02;
    year_bcd  = 8'h23;
    start(4'd3, 8'h28);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h01) $display("FAIL feb_common_wrap actual=%h required=01", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    year_bcd = 8'h24;
    start(4'd3, 8'h28);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bcd_out !== 8'h29) $display("FAIL feb_leap_up actual=%h required=29", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    start(4'd3, 8'h30);
    total++; if (bcd_out !== 8'h01) $display("FAIL feb_capture_over actual=%h required=01", bcd_out); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    month_bcd = 8'h01;
    year_bcd  = 8'h00;
  endtask
`endif

  initial begin
    reset = 1'b0;
    Ld_BCD = 8'h00; sel_LD = 4'h0;
    month_bcd = 8'h01; year_bcd = 8'h00;
    edit_start = 1'b0; btn_up = 1'b0; btn_down = 1'b0; edit_commit = 1'b0; edit_cancel = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    #1 reset = 1'b1;
    @(negedge clk);
    test_seg_wrap;
    test_month;
    test_hour;
    test_year;
    test_day;
    test_raw_code;
    test_reset_mid_edit;
`ifdef DAY_LIMIT_MONTH_EN
    test_day_limit;
`endif
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) $display("FAIL pending_writes actual=%0d required=0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
